// File: rtl/mips_pkg.sv
// Shared MIPS encodings: ALU control codes, mul/div opcodes and the
// sequencer state encoding used by the iterative multiply/divide unit.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_DIVU  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MUL  = 2'b01;
  localparam logic [1:0] ST_DIV  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative 32-step unsigned multiply / restoring divide that borrows the
// external shared ALU for its add/subtract each cycle.
module alu_muldiv_seq
  import mips_pkg::*;
#(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_out
);

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [31:0] breg;
  logic [31:0] acc;
  logic [31:0] sh;
  logic [31:0] acc_nxt;
  logic [31:0] sh_nxt;
  logic [31:0] rsh;
  logic        carry;
  logic        take;
  logic        last;

  assign last = (cnt == 6'(STEPS - 1));
  assign rsh  = {acc[30:0], sh[31]};

  // acc holds the product high half (MUL) or the partial remainder (DIV);
  // sh holds the shifting multiplier/product low half or the quotient.
  always_comb begin
    alu_ctrl = ALU_ADD;
    alu_in1  = '0;
    alu_in2  = '0;
    acc_nxt  = acc;
    sh_nxt   = sh;
    carry    = 1'b0;
    take     = 1'b0;
    case (state)
      ST_MUL: begin
        alu_in1 = acc;
        alu_in2 = sh[0] ? breg : '0;
        carry   = (alu_out < acc);
        {acc_nxt, sh_nxt} = {carry, alu_out, sh[31:1]};
      end
      ST_DIV: begin
        alu_ctrl = ALU_SUB;
        alu_in1  = rsh;
        alu_in2  = breg;
        // A set acc[31] means the true 33-bit partial remainder exceeds b.
        take     = acc[31] | (rsh >= breg);
        acc_nxt  = take ? alu_out : rsh;
        sh_nxt   = {sh[30:0], take};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      breg        <= '0;
      acc         <= '0;
      sh          <= '0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (op == OP_MULTU || op == OP_DIVU)) begin
            breg <= b;
            acc  <= '0;
            sh   <= a;
            cnt  <= '0;
            if (op == OP_MULTU) begin
              state <= ST_MUL;
            end else if (b == 32'd0) begin
              state       <= ST_DONE;
              hi          <= a;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc <= acc_nxt;
          sh  <= sh_nxt;
          cnt <= cnt + 6'd1;
          if (last) begin
            state       <= ST_DONE;
            hi          <= acc_nxt;
            lo          <= sh_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: supplies the shared ALU, keeps a latency-level
// reference model checked every cycle, and runs directed vectors.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo, alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_ctrl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.STEPS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out)
  );

  // Shared combinational ALU owned by the surrounding datapath
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_out = alu_in1 & alu_in2;
      3'b001:  alu_out = alu_in1 | alu_in2;
      3'b010:  alu_out = alu_in1 + alu_in2;
      3'b110:  alu_out = alu_in1 - alu_in2;
      3'b111:  alu_out = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      default: alu_out = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: results from plain arithmetic, timing as a countdown
  logic        m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_rem = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_rem = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_hi = p_hi; m_lo = p_lo; m_dbz = 1'b0;
      end
    end else if (start && op == 2'b00) begin
      m_busy = 1'b1; m_rem = 32;
      {p_hi, p_lo} = 64'(a) * 64'(b);
    end else if (start && op == 2'b01) begin
      if (b == 32'd0) begin
        m_done = 1'b1; m_hi = a; m_lo = '1; m_dbz = 1'b1;
      end else begin
        m_busy = 1'b1; m_rem = 32;
        p_hi = a % b; p_lo = a / b;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("busy", 32'(busy), 32'(m_busy | m_done));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("hi", hi, m_hi);
      checkOutput("lo", lo, m_lo);
      checkOutput("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end
  end

  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; lat counts negedges after accept
  task automatic waitDone(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("done_seen", 32'(done), 32'd1);
  endtask

  task automatic runOp(input string name, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int exp_lat, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic exp_dbz);
    int lat;
    applyStimulus(o, x, y);
    waitDone(lat);
    checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_hi"}, hi, exp_hi);
    checkOutput({name, "_lo"}, lo, exp_lo);
    checkOutput({name, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    int lat;
    int pulses;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;

    runOp("mul_7x6", 2'b00, 32'd7, 32'd6, 33, 32'd0, 32'd42, 1'b0);
    runOp("mul_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    runOp("div_100_7", 2'b01, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);
    runOp("div_max_1", 2'b01, 32'hFFFFFFFF, 32'd1, 33, 32'd0, 32'hFFFFFFFF, 1'b0);
    runOp("div_by_0", 2'b01, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF, 1'b1);
    runOp("mul_3x5", 2'b00, 32'd3, 32'd5, 33, 32'd0, 32'd15, 1'b0);

    // Issued straight after DONE; a second start lands at step 5 and must be ignored
    applyStimulus(2'b01, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      if (done) begin
        checkOutput("busy_start_hi", hi, 32'd2);
        checkOutput("busy_start_lo", lo, 32'd14);
      end
      @(negedge clk);
    end
    checkOutput("busy_start_pulses", 32'(pulses), 32'd1);

    applyStimulus(2'b10, 32'd4, 32'd4);
    checkOutput("reserved10_busy", 32'(busy), 32'd0);
    applyStimulus(2'b11, 32'd4, 32'd4);
    checkOutput("reserved11_busy", 32'(busy), 32'd0);

    // Reset at step 10 of a multiply, with a start in the same cycle
    applyStimulus(2'b00, 32'd9, 32'd9);
    repeat (8) @(negedge clk);
    rst_n = 1'b0; start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checkOutput("abort_pulses", 32'(pulses), 32'd0);
    runOp("mul_after_abort", 2'b00, 32'd9, 32'd9, 33, 32'd0, 32'd81, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
